// File: rtl/sd_pkg.sv
// Shared definitions for the SD command-response receiver.
//   state_e    : receiver FSM states
//   SHORT_LEN  : R1/R3/R6/R7 frame length on the wire (bits)
//   LONG_LEN   : R2 frame length on the wire (bits)
//   HDR_LEN    : start + transmission + 6-bit index/reserved field
//   TAIL_LEN   : 7-bit CRC plus end bit
//   CRC7_POLY  : x^7 + x^3 + 1 without the implicit x^7 term
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        SHIFT,
        CHECK,
        DONE
    } state_e;

    localparam int         SHORT_LEN = 48;
    localparam int         LONG_LEN  = 136;
    localparam int         HDR_LEN   = 8;
    localparam int         TAIL_LEN  = 8;
    localparam logic [6:0] CRC7_POLY = 7'h09;

endpackage

// File: rtl/crc7_step.sv
// Combinational single-bit CRC7 update, MSB-first serial form.
//   data_i : incoming bit
//   crc_i  : current CRC register
//   crc_o  : CRC register after absorbing data_i
module crc7_step
    import sd_pkg::*;
(
    input  logic       data_i,
    input  logic [6:0] crc_i,
    output logic [6:0] crc_o
);

    logic fb;

    assign fb    = data_i ^ crc_i[6];
    assign crc_o = {crc_i[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);

endmodule

// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver (48-bit R1/R3/R6/R7 and 136-bit R2).
// Waits up to NCR_MAX SD-clock samples for the start bit, shifts the frame in
// MSB-first, checks CRC7, transmission bit and end bit, then pulses done.
//   clk, resetn        : clock, synchronous active-low reset
//   sd_clk_en          : SD clock rising-edge strobe, qualifies cmd_in
//   cmd_in             : synchronised CMD line
//   start              : arms reception (ignored while busy)
//   long_resp          : 1 = R2 frame, latched at start
//   crc_chk_en         : 0 masks crc_err, latched at start
//   busy, done         : activity flag and one-cycle completion pulse
//   resp_index/arg     : short-frame fields
//   resp_long          : R2 content bits [127:8]
//   crc_err/frame_err/timeout : status, held until the next start
module sd_resp_rx
    import sd_pkg::*;
#(
    parameter int NCR_MAX = 64
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         sd_clk_en,
    input  logic         cmd_in,
    input  logic         start,
    input  logic         long_resp,
    input  logic         crc_chk_en,
    output logic         busy,
    output logic         done,
    output logic [5:0]   resp_index,
    output logic [31:0]  resp_arg,
    output logic [119:0] resp_long,
    output logic         crc_err,
    output logic         frame_err,
    output logic         timeout
);

    localparam int WAIT_W = $clog2(NCR_MAX) + 1;

    state_e              state_q, state_d;
    logic [7:0]          bit_cnt_q, bit_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [6:0]          crc_q, crc_d, crc_step_val;
    logic [6:0]          rx_crc_q, rx_crc_d;
    logic [119:0]        shreg_q, shreg_d;
    logic                long_q, long_d;
    logic                chk_q, chk_d;
    logic [5:0]          idx_q, idx_d;
    logic [31:0]         arg_q, arg_d;
    logic [119:0]        ldata_q, ldata_d;
    logic                crc_err_q, crc_err_d;
    logic                frame_err_q, frame_err_d;
    logic                timeout_q, timeout_d;

    logic [7:0]          frame_len;
    logic [7:0]          last_cov;
    logic                in_crc;

    crc7_step u_crc7 (
        .data_i (cmd_in),
        .crc_i  (crc_q),
        .crc_o  (crc_step_val)
    );

    assign frame_len = long_q ? 8'(LONG_LEN) : 8'(SHORT_LEN);
    assign last_cov  = frame_len - 8'(TAIL_LEN);
    // bit_cnt_q counts bits already sampled, so the current bit is bit_cnt_q+1;
    // R2 frames keep the 8 header bits out of the CRC.
    assign in_crc    = !long_q || (bit_cnt_q >= 8'(HDR_LEN));

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        crc_d       = crc_q;
        rx_crc_d    = rx_crc_q;
        shreg_d     = shreg_q;
        long_d      = long_q;
        chk_d       = chk_q;
        idx_d       = idx_q;
        arg_d       = arg_q;
        ldata_d     = ldata_q;
        crc_err_d   = crc_err_q;
        frame_err_d = frame_err_q;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = WAIT_START;
                    bit_cnt_d   = 8'd0;
                    wait_cnt_d  = '0;
                    crc_d       = 7'd0;
                    rx_crc_d    = 7'd0;
                    crc_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                    timeout_d   = 1'b0;
                    long_d      = long_resp;
                    chk_d       = crc_chk_en;
                end
            end
            WAIT_START: begin
                if (sd_clk_en) begin
                    if (!cmd_in) begin
                        // Start bit is the first frame bit: count, shift and CRC it.
                        state_d   = SHIFT;
                        bit_cnt_d = 8'd1;
                        shreg_d   = {shreg_q[118:0], cmd_in};
                        if (in_crc) crc_d = crc_step_val;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                        if (wait_cnt_d == WAIT_W'(NCR_MAX)) begin
                            state_d   = DONE;
                            timeout_d = 1'b1;
                        end
                    end
                end
            end
            SHIFT: begin
                if (sd_clk_en) begin
                    shreg_d   = {shreg_q[118:0], cmd_in};
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (in_crc) crc_d = crc_step_val;
                    if (bit_cnt_q == 8'd1 && cmd_in) frame_err_d = 1'b1;
                    if (bit_cnt_d == last_cov) state_d = CHECK;
                end
            end
            CHECK: begin
                if (sd_clk_en) begin
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (bit_cnt_d == frame_len) begin
                        state_d   = DONE;
                        crc_err_d = chk_q && (rx_crc_q != crc_q);
                        if (!cmd_in) frame_err_d = 1'b1;
                        // Shifting stopped at the last covered bit, so the
                        // payload sits right-aligned in shreg_q.
                        if (long_q) begin
                            ldata_d = shreg_q;
                        end else begin
                            idx_d = shreg_q[37:32];
                            arg_d = shreg_q[31:0];
                        end
                    end else begin
                        rx_crc_d = {rx_crc_q[5:0], cmd_in};
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 8'd0;
            wait_cnt_q  <= '0;
            crc_q       <= 7'd0;
            rx_crc_q    <= 7'd0;
            shreg_q     <= '0;
            long_q      <= 1'b0;
            chk_q       <= 1'b0;
            idx_q       <= 6'd0;
            arg_q       <= 32'd0;
            ldata_q     <= '0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            crc_q       <= crc_d;
            rx_crc_q    <= rx_crc_d;
            shreg_q     <= shreg_d;
            long_q      <= long_d;
            chk_q       <= chk_d;
            idx_q       <= idx_d;
            arg_q       <= arg_d;
            ldata_q     <= ldata_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
        end
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign resp_index = idx_q;
    assign resp_arg   = arg_q;
    assign resp_long  = ldata_q;
    assign crc_err    = crc_err_q;
    assign frame_err  = frame_err_q;
    assign timeout    = timeout_q;

endmodule
